// File: rtl/imm_decode_stage.sv
// ============================================================================
// imm_decode_stage : registered RV32I immediate decode with two-entry skid buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module imm_decode_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [3:0]  ImmSel,
   output logic [31:0] Bimm,
   output logic [31:0] Iimm,
   output logic [31:0] Jimm,
   output logic [31:0] Simm,
   output logic [31:0] Uimm,
   output logic        illegal
);

   localparam logic [3:0] c_sel_bis  = 4'd0;
   localparam logic [3:0] c_sel_iis  = 4'd1;
   localparam logic [3:0] c_sel_jis  = 4'd2;
   localparam logic [3:0] c_sel_sis  = 4'd3;
   localparam logic [3:0] c_sel_uis  = 4'd4;
   localparam logic [3:0] c_sel_none = 4'hF;

   typedef struct packed {
      logic [31:0] instr;
      logic [3:0]  sel;
      logic        illegal;
      logic [31:0] bimm;
      logic [31:0] iimm;
      logic [31:0] jimm;
      logic [31:0] simm;
      logic [31:0] uimm;
   } bundle_t;

   localparam bundle_t c_bundle_rst = '{
      instr: 32'd0, sel: c_sel_none, illegal: 1'b0,
      bimm: 32'd0, iimm: 32'd0, jimm: 32'd0, simm: 32'd0, uimm: 32'd0
   };

   bundle_t dec;
   bundle_t main_d, main_q;
   bundle_t skid_d, skid_q;
   logic    main_valid_d, main_valid_q;
   logic    skid_valid_d, skid_valid_q;
   logic    in_ready_d, in_ready_q;
   logic    accept;
   logic    pop;

   // Decode happens before storage so the outputs come straight from flops.
   always_comb begin
      dec         = c_bundle_rst;
      dec.instr   = in_instr;
      dec.iimm    = {{20{in_instr[31]}}, in_instr[31:20]};
      dec.simm    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      dec.bimm    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
      dec.jimm    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
      dec.uimm    = {in_instr[31:12], 12'h000};
      dec.sel     = c_sel_none;
      dec.illegal = 1'b0;
      case (in_instr[6:0])
         7'b0000011, 7'b0010011,
         7'b1100111, 7'b1110011: dec.sel = c_sel_iis;
         7'b0100011:             dec.sel = c_sel_sis;
         7'b1100011:             dec.sel = c_sel_bis;
         7'b1101111:             dec.sel = c_sel_jis;
         7'b0110111, 7'b0010111: dec.sel = c_sel_uis;
         7'b0110011:             dec.sel = c_sel_none;
         default:                dec.illegal = 1'b1;
      endcase
   end

   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      accept       = in_valid && in_ready_q;
      pop          = main_valid_q && out_ready;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (pop) begin
         // With skid occupied in_ready is low, so no accept can coincide here.
         if (skid_valid_q) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_d = dec;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (!main_valid_q) begin
            main_d       = dec;
            main_valid_d = 1'b1;
         end else begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
         end
      end
      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_q       <= c_bundle_rst;
         skid_q       <= c_bundle_rst;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = main_valid_q;
   assign out_instr = main_q.instr;
   assign ImmSel    = main_q.sel;
   assign illegal   = main_q.illegal;
   assign Bimm      = main_q.bimm;
   assign Iimm      = main_q.iimm;
   assign Jimm      = main_q.jimm;
   assign Simm      = main_q.simm;
   assign Uimm      = main_q.uimm;

endmodule

`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
// ============================================================================
// tb_imm_decode_stage : directed + randomized check of imm_decode_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_imm_decode_stage;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready, illegal;
   logic [31:0] in_instr, out_instr, Bimm, Iimm, Jimm, Simm, Uimm;
   logic [3:0]  ImmSel;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mq[$];

   imm_decode_stage dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .ImmSel(ImmSel), .Bimm(Bimm), .Iimm(Iimm), .Jimm(Jimm),
      .Simm(Simm), .Uimm(Uimm), .illegal(illegal)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_i(input logic [31:0] w);
      return 32'($signed(w) >>> 20);
   endfunction
   function automatic logic [31:0] ref_s(input logic [31:0] w);
      return (32'($signed(w) >>> 25) << 5) | 32'(w[11:7]);
   endfunction
   function automatic logic [31:0] ref_b(input logic [31:0] w);
      return (32'($signed(w) >>> 31) << 12) | (32'(w[7]) << 11)
           | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
   endfunction
   function automatic logic [31:0] ref_j(input logic [31:0] w);
      return (32'($signed(w) >>> 31) << 20) | (32'(w[19:12]) << 12)
           | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
   endfunction
   function automatic logic [31:0] ref_u(input logic [31:0] w);
      return w & 32'hFFFFF000;
   endfunction
   function automatic logic [4:0] ref_class(input logic [31:0] w);
      // {illegal, sel}
      case (w[6:0])
         7'h03, 7'h13, 7'h67, 7'h73: return {1'b0, 4'd1};
         7'h23:                      return {1'b0, 4'd3};
         7'h63:                      return {1'b0, 4'd0};
         7'h6F:                      return {1'b0, 4'd2};
         7'h37, 7'h17:               return {1'b0, 4'd4};
         7'h33:                      return {1'b0, 4'hF};
         default:                    return {1'b1, 4'hF};
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic [31:0] h;
      logic [4:0]  cls;
      check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      check("in_ready", 32'(in_ready), 32'(mq.size() < 2));
      if (mq.size() > 0) begin
         h   = mq[0];
         cls = ref_class(h);
         check("out_instr", out_instr, h);
         check("ImmSel", 32'(ImmSel), 32'(cls[3:0]));
         check("illegal", 32'(illegal), 32'(cls[4]));
         check("Iimm", Iimm, ref_i(h));
         check("Simm", Simm, ref_s(h));
         check("Bimm", Bimm, ref_b(h));
         check("Jimm", Jimm, ref_j(h));
         check("Uimm", Uimm, ref_u(h));
      end
   endtask

   task automatic check_reset_values();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_ImmSel", 32'(ImmSel), 32'hF);
      check("rst_illegal", 32'(illegal), 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_imm_or", Bimm | Iimm | Jimm | Simm | Uimm, 32'd0);
   endtask

   // One clock cycle: drive inputs, advance the FIFO model, compare.
   task automatic cycle(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
      logic acc, pp;
      in_valid  = v;
      in_instr  = w;
      out_ready = ordy;
      flush     = fl;
      acc = v && (mq.size() < 2);
      pp  = (mq.size() > 0) && ordy;
      @(posedge clk);
      #1;
      if (fl || rst) begin
         mq.delete();
      end else begin
         if (pp) void'(mq.pop_front());
         if (acc) mq.push_back(w);
      end
      check_outputs();
   endtask

   logic [6:0] ops[11] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63,
                           7'h6F, 7'h37, 7'h17, 7'h33, 7'h7F};

   initial begin
      int accepted;
      int budget;
      logic [31:0] w;
      logic v;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b0;
      cycle(0, 32'd0, 0, 0);
      cycle(0, 32'd0, 0, 0);
      check_reset_values();
      rst = 1'b0;

      // addi x1,x0,-1
      cycle(1, 32'hFFF00093, 1, 0);
      check("addi_sel", 32'(ImmSel), 32'd1);
      check("addi_iimm", Iimm, 32'hFFFFFFFF);
      check("addi_ready", 32'(in_ready), 32'd1);

      // back-to-back stream
      cycle(1, 32'hFE112E23, 1, 0);
      check("sw_sel", 32'(ImmSel), 32'd3);
      check("sw_simm", Simm, 32'hFFFFFFFC);
      cycle(1, 32'hFE000FE3, 1, 0);
      check("beq_sel", 32'(ImmSel), 32'd0);
      check("beq_bimm", Bimm, 32'hFFFFFFFE);
      cycle(1, 32'h001000EF, 1, 0);
      check("jal_sel", 32'(ImmSel), 32'd2);
      check("jal_jimm", Jimm, 32'h00000800);
      cycle(1, 32'h123450B7, 1, 0);
      check("lui_sel", 32'(ImmSel), 32'd4);
      check("lui_uimm", Uimm, 32'h12345000);
      cycle(0, 32'd0, 1, 0);

      // backpressure: three words offered, two accepted
      cycle(1, 32'h00000033, 0, 0);
      check("add_sel", 32'(ImmSel), 32'hF);
      check("add_illegal", 32'(illegal), 32'd0);
      cycle(1, 32'h0000007F, 0, 0);
      check("bp_ready_low", 32'(in_ready), 32'd0);
      cycle(1, 32'h00A00113, 0, 0);
      check("bp_head_held", out_instr, 32'h00000033);
      cycle(1, 32'h00A00113, 1, 0);
      check("ill_sel", 32'(ImmSel), 32'hF);
      check("ill_illegal", 32'(illegal), 32'd1);
      cycle(1, 32'h00A00113, 1, 0);
      cycle(0, 32'd0, 1, 0);
      cycle(0, 32'd0, 1, 0);

      // flush with both entries full and a word presented
      cycle(1, 32'h00100093, 0, 0);
      cycle(1, 32'h00200093, 0, 0);
      cycle(1, 32'hDEADB037, 0, 1);
      check("flush_valid", 32'(out_valid), 32'd0);
      check("flush_ready", 32'(in_ready), 32'd1);
      cycle(0, 32'd0, 1, 0);

      // randomized stream against the FIFO model
      accepted = 0;
      budget   = 0;
      while (accepted < 1000 && budget < 10000) begin
         w = $urandom;
         if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 10)];
         v = ($urandom_range(0, 3) != 0);
         if (v && mq.size() < 2) accepted++;
         cycle(v, w, 1'($urandom_range(0, 1)), 0);
         budget++;
      end
      check("random_budget", 32'(accepted >= 1000), 32'd1);

      // reset mid-stream
      cycle(1, 32'h00300093, 0, 0);
      cycle(1, 32'h00400093, 0, 0);
      rst = 1'b1;
      cycle(1, 32'h00500093, 1'($urandom_range(0, 1)), 0);
      check_reset_values();
      rst = 1'b0;
      cycle(0, 32'd0, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered immediate-decode stage for the RV32I datapath. Accepts fetched 32-bit instruction words over a valid/ready handshake, classifies the opcode into the ImmSel code consumed by the ALU immediate mux, and produces all five sign-extended immediates (B, I, J, S, U) from registers. A two-entry skid buffer (main plus skid) gives full throughput with a registered `in_ready`. Sits between fetch and the immediate mux/execute stage.

## Interface
- No parameters; data width is fixed at 32, ImmSel width at 4.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous pipeline flush; drops all held entries
- `in_valid`  in  1  instruction word valid
- `in_ready`  out  1  stage can accept; registered
- `in_instr`  in  32  instruction word
- `out_valid`  out  1  decoded entry valid
- `out_ready`  in  1  downstream accepts
- `out_instr`  out  32  instruction word of the head entry
- `ImmSel`  out  4  immediate select: BIS=0, IIS=1, JIS=2, SIS=3, UIS=4, NONE=15
- `Bimm`, `Iimm`, `Jimm`, `Simm`, `Uimm`  out  32 each  decoded immediates of the head entry
- `illegal`  out  1  head entry has an unrecognised opcode

## Operation
- Opcode `instr[6:0]` classification: 0000011, 0010011, 1100111, 1110011 -> IIS; 0100011 -> SIS; 1100011 -> BIS; 1101111 -> JIS; 0110111, 0010111 -> UIS; 0110011 -> NONE with illegal=0; anything else -> NONE with illegal=1.
- Immediates are always computed for every word, regardless of class:
  - I: sext(i[31:20])
  - S: sext({i[31:25], i[11:7]})
  - B: sext({i[31], i[7], i[30:25], i[11:8], 1'b0})
  - J: sext({i[31], i[19:12], i[20], i[30:21], 1'b0})
  - U: {i[31:12], 12'h000}
- Decoding happens on the input side, and the decoded bundle is stored. There is no combinational path from `in_*` to `out_*`.
- Storage is a main register (drives the outputs) and a skid register, each with a valid bit.
- `in_ready` = !skid_valid, registered.
- Accept occurs when in_valid && in_ready. On accept:
  - If main is empty, or main is valid and out_ready is high, the bundle loads into main.
  - Otherwise the bundle loads into skid.
- Pop occurs when out_valid && out_ready. If skid is valid, skid moves into main and skid is cleared. If there is no skid entry and no accept, main_valid clears.
- Data order is strictly FIFO. No entry is dropped or duplicated except on flush or reset.
- `flush` takes priority over accept and pop. Both valids clear at the next edge, the input word in that cycle is discarded, and in_ready is 1 the next cycle.
- Data fields of invalid entries are don't-care, except after reset (see Timing).

## Timing
- Reset values: out_valid=0, in_ready=1, ImmSel=4'hF, illegal=0, out_instr=0, all immediates=0. The skid register is empty.
- `rst` asserted mid-transfer discards both entries, with the same result as flush.
- Latency: a word accepted at edge N appears on the outputs (out_valid=1) after edge N, so it is visible in cycle N+1.
- Throughput: one word per cycle while out_ready is held high; in_ready stays 1.
- When out_ready drops while main is valid:
  - One more word is accepted into skid.
  - in_ready goes low the following cycle and stays low until skid drains.
- Simultaneous accept and pop with skid empty: main is replaced with the new bundle, and out_valid stays 1.
- Simultaneous accept and pop with skid full cannot occur, because in_ready=0.
- Outputs must be held stable while out_valid && !out_ready.

## Test plan
- Reset, then stream 0xFFF00093 (addi x1,x0,-1) with out_ready=1 -> next cycle: ImmSel=1, Iimm=0xFFFFFFFF, illegal=0, in_ready stays 1.
- Back-to-back stream with out_ready=1:
  - 0xFE112E23 (sw) -> ImmSel=3, Simm=0xFFFFFFFC
  - 0xFE000FE3 (beq -2) -> ImmSel=0, Bimm=0xFFFFFFFE
  - 0x001000EF (jal +2048) -> ImmSel=2, Jimm=0x00000800
  - 0x123450B7 (lui) -> ImmSel=4, Uimm=0x12345000
  - Required: one output per cycle, in order.
- Backpressure: hold out_ready=0 and present 3 words -> 2 accepted, in_ready=0 from the cycle after the second accept. Release out_ready -> both emerge in order, then the third is accepted.
- 0x00000033 (add) -> ImmSel=15, illegal=0. 0x0000007F -> ImmSel=15, illegal=1.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1. The flushed-cycle word never appears on the outputs.
- Assert `rst` mid-stream with out_ready toggling randomly -> all outputs return to their reset values on the next cycle. A scoreboard confirms FIFO order for the 1000-word random run before reset.
